// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcode/funct
// encodings, ALU operation codes and the decoder's coarse ALU-op selector.
package multicycle_control_unit_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
      ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR
   } state_t;

   // Coarse ALU request from the FSM; ALUOP_NONE yields an all-zero control.
   typedef enum logic [1:0] {
      ALUOP_NONE, ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_unit_alu_control_decoder.sv
// ALU control decoder: maps the FSM's coarse ALU request (and the R-type funct
// field when requested) onto the ALU operation code, zero-extended to ALUCTL_W.
module alu_control_decoder
   import multicycle_control_unit_pkg::*;
#(
   parameter int FUNCT_W  = 6,
   parameter int ALUCTL_W = 3
) (
   input  logic [1:0]          alu_op,
   input  logic [FUNCT_W-1:0]  funct,
   output logic [ALUCTL_W-1:0] alu_control
);

   alu_op_t    op_sel;
   logic [2:0] code;

   assign op_sel = alu_op_t'(alu_op);

   always_comb begin
      code = 3'b000;
      unique case (op_sel)
         ALUOP_NONE: code = 3'b000;
         ALUOP_ADD:  code = ALU_ADD;
         ALUOP_SUB:  code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_W'(FUNCT_ADD): code = ALU_ADD;
               FUNCT_W'(FUNCT_SUB): code = ALU_SUB;
               FUNCT_W'(FUNCT_AND): code = ALU_AND;
               FUNCT_W'(FUNCT_OR):  code = ALU_OR;
               FUNCT_W'(FUNCT_SLT): code = ALU_SLT;
               default:             code = ALU_ADD;
            endcase
         end
      endcase
   end

   assign alu_control = ALUCTL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control unit: one FSM whose state (plus mem_ready, zero
// and funct where relevant) decodes combinationally into the datapath controls.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int FUNCT_W  = 6,
   parameter int ALUCTL_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     op,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                mem_ready,
   input  logic                zero,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                illegal_op
);

   state_t  state, state_next, dec_state;
   alu_op_t alu_op;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_next;
   end

   // While reset is held the outputs already present the FETCH decode.
   assign dec_state = rst_n ? state : FETCH;

   always_comb begin
      state_next = dec_state;
      alu_op     = ALUOP_NONE;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      illegal_op = 1'b0;
      case (dec_state)
         FETCH: begin
            alu_src_b = 2'b01;
            alu_op    = ALUOP_ADD;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = ALUOP_ADD;
            if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_next = MEMADR;
            else if (op == OP_W'(OP_RTYPE))               state_next = EXECUTE;
            else if (op == OP_W'(OP_BEQ))                 state_next = BRANCH;
            else if (op == OP_W'(OP_ADDI))                state_next = ADDIEX;
            else if (op == OP_W'(OP_J))                   state_next = JUMP;
            else                                          state_next = ERROR;
         end
         MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = ALUOP_ADD;
            state_next = (op == OP_W'(OP_LW)) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord = 1'b1;
            if (mem_ready) state_next = MEMWB;
         end
         MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_next = FETCH;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_SUB;
            pc_src     = 2'b01;
            pc_en      = zero;
            state_next = FETCH;
         end
         ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = ALUOP_ADD;
            state_next = ADDIWB;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         JUMP: begin
            pc_src     = 2'b10;
            pc_en      = 1'b1;
            state_next = FETCH;
         end
         ERROR: begin
            illegal_op = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   alu_control_decoder #(
      .FUNCT_W  (FUNCT_W),
      .ALUCTL_W (ALUCTL_W)
   ) u_alu_dec (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instruction scenarios with literal
// expectations, then randomized traffic compared against an instruction-step model.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, mem_ready, zero;
   logic [5:0] op, funct;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic       illegal_op;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready), .zero(zero),
      .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .illegal_op(illegal_op)
   );

   typedef struct packed {
      logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, pc_src;
      logic [2:0] alu_control;
      logic       illegal_op;
   } ctl_t;

   ctl_t dut_ctl;
   assign dut_ctl = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction steps; each instruction class is a fixed walk through them.
   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6,
                  AWB = 7, BR = 8, AE = 9, AIWB = 10, J = 11, ERR = 12;
   int seq_tab [7][5] = '{'{F, D, MA, MR, MWB},  // lw
                          '{F, D, MA, MW, F},    // sw
                          '{F, D, EX, AWB, F},   // R-type
                          '{F, D, BR, F, F},     // beq
                          '{F, D, AE, AIWB, F},  // addi
                          '{F, D, J, F, F},      // j
                          '{F, D, ERR, F, F}};   // unsupported
   int seq_len [7] = '{5, 4, 4, 3, 4, 3, 3};
   int m_cls = 0;
   int m_idx = 0;

   function automatic int op_class(logic [5:0] o);
      case (o)
         6'b100011: return 0;
         6'b101011: return 1;
         6'b000000: return 2;
         6'b000100: return 3;
         6'b001000: return 4;
         6'b000010: return 5;
         default:   return 6;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic ctl_t exp_out(int st, logic mr, logic z, logic [5:0] f);
      ctl_t e = '0;
      case (st)
         F:    begin e.alu_src_b = 2'b01; e.alu_control = 3'b010; e.ir_write = mr; e.pc_en = mr; end
         D:    begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; end
         MA,
         AE:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
         MR:   e.iord = 1'b1;
         MW:   begin e.iord = 1'b1; e.mem_write = 1'b1; end
         MWB:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
         EX:   begin e.alu_src_a = 1'b1; e.alu_control = funct_alu(f); end
         AWB:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
         BR:   begin e.alu_src_a = 1'b1; e.alu_control = 3'b110; e.pc_src = 2'b01; e.pc_en = z; end
         AIWB: e.reg_write = 1'b1;
         J:    begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
         ERR:  e.illegal_op = 1'b1;
         default: e = '0;
      endcase
      return e;
   endfunction

   always @(posedge clk) begin
      int st;
      st = seq_tab[m_cls][m_idx];
      if (!rst_n) m_idx = 0;
      else if (st == D) begin
         m_cls = op_class(op);
         m_idx = 2;
      end else if (st == ERR) begin
         m_idx = m_idx;
      end else if ((st == F || st == MR || st == MW) && !mem_ready) begin
         m_idx = m_idx;
      end else begin
         m_idx++;
         if (m_idx >= seq_len[m_cls]) m_idx = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int st;
         st = rst_n ? seq_tab[m_cls][m_idx] : F;
         check("model_ctl", 32'(dut_ctl), 32'(exp_out(st, mem_ready, zero, funct)));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      int mw_cnt;
      rst_n = 1'b0; op = 6'b0; funct = 6'b0; mem_ready = 1'b1; zero = 1'b0;
      tick;
      chk_en = 1'b1;
      settle;
      check("rst_ir_write", 32'(ir_write), 1);
      check("rst_pc_en", 32'(pc_en), 1);
      check("rst_alu_src_b", 32'(alu_src_b), 1);
      check("rst_alu_control", 32'(alu_control), 3'b010);
      check("rst_illegal", 32'(illegal_op), 0);
      mem_ready = 1'b0;
      settle;
      check("rst_pc_en_wait", 32'(pc_en), 0);
      tick;

      // lw, no waits
      rst_n = 1'b1; mem_ready = 1'b1; op = 6'b100011;
      settle; check("lw_fetch_ir_write", 32'(ir_write), 1);
      tick; settle; check("lw_decode_srcb", 32'(alu_src_b), 2'b11);
      tick; settle; check("lw_memadr_srcb", 32'(alu_src_b), 2'b10);
      tick; settle; check("lw_memrd_iord", 32'(iord), 1);
      tick; settle; check("lw_memwb_wr", 32'({reg_write, mem_to_reg, reg_dst}), 3'b110);
      tick; settle; check("lw_back_fetch", 32'(alu_src_b), 2'b01);

      // R-type slt
      op = 6'b000000; funct = 6'b101010;
      tick; tick; settle; check("slt_execute_alu", 32'(alu_control), 3'b111);
      tick; settle; check("slt_aluwb", 32'({reg_dst, reg_write}), 2'b11);
      tick; settle; check("slt_back_fetch", 32'({alu_src_b, reg_write}), 3'b010);

      // sw with three wait cycles
      op = 6'b101011;
      tick; tick; tick;
      mw_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         settle;
         if (mem_write) mw_cnt++;
         tick;
      end
      settle;
      check("sw_mem_write_cycles", 32'(mw_cnt), 4);
      check("sw_back_fetch", 32'({mem_write, alu_src_b}), 3'b001);

      // beq taken, then not taken
      op = 6'b000100;
      tick; tick; zero = 1'b1; settle;
      check("beq_taken", 32'({pc_en, pc_src, alu_control}), 6'b1_01_110);
      tick; tick; tick; zero = 1'b0; settle;
      check("beq_not_taken", 32'({pc_en, pc_src}), 3'b0_01);
      tick;

      // unsupported opcode locks in ERROR until reset
      op = 6'b111111;
      tick; tick;
      for (int i = 0; i < 10; i++) begin
         settle;
         check("err_illegal", 32'({illegal_op, ir_write, pc_en}), 3'b100);
         tick;
      end
      rst_n = 1'b0;
      tick; rst_n = 1'b1; settle;
      check("err_reset_clears", 32'({illegal_op, alu_src_b, ir_write}), 4'b0_01_1);

      // reset during a MEMRD wait
      op = 6'b100011;
      tick; tick; tick; mem_ready = 1'b0; settle;
      check("memrd_wait_iord", 32'(iord), 1);
      rst_n = 1'b0;
      tick; rst_n = 1'b1; settle;
      check("memrd_reset_fetch", 32'({iord, alu_src_b, pc_en}), 4'b0_01_0);
      mem_ready = 1'b1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         tick;
         if (seq_tab[m_cls][m_idx] == ERR) rst_n = ($urandom_range(0, 4) != 0);
         else                              rst_n = ($urandom_range(0, 59) != 0);
         if (m_idx == 0) begin
            case ($urandom_range(0, 9))
               0: op = 6'b100011;
               1: op = 6'b101011;
               2: op = 6'b000000;
               3: op = 6'b000100;
               4: op = 6'b001000;
               5: op = 6'b000010;
               default: op = 6'($urandom_range(0, 63));
            endcase
         end
         case ($urandom_range(0, 5))
            0: funct = 6'b100000;
            1: funct = 6'b100010;
            2: funct = 6'b100100;
            3: funct = 6'b100101;
            4: funct = 6'b101010;
            default: funct = 6'($urandom_range(0, 63));
         endcase
         zero      = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
      end
      tick;
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
